// File: rtl/alu_serial_if.sv
// Request/response bundle between the control unit and the bit-serial ALU.
// The control unit (master) issues operands and a start strobe; the ALU
// (slave) reports busy/done and the registered result with its flags.
interface alu_serial_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ALU_control_i;
  logic [2:0]       bonus_control_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             cout_o;
  logic             overflow_o;

  modport master (
    output start_i, src1_i, src2_i, ALU_control_i, bonus_control_i,
    input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o
  );

  modport slave (
    input  start_i, src1_i, src2_i, ALU_control_i, bonus_control_i,
    output busy_o, done_o, result_o, zero_o, cout_o, overflow_o
  );
endinterface

// File: rtl/alu_serial.sv
// Bit-serial ALU: one 1-bit slice walks the latched operands LSB to MSB,
// one bit per clock, then a single FINISH cycle folds the carry history
// into overflow/compare results and registers the visible outputs.
module alu_serial #(
  parameter int WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_n,
  alu_serial_if.slave bus
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0] LAST_K = KW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [2:0]       bonus_q, bonus_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             eq_q, eq_d;
  logic             cinMsb_q, cinMsb_d;
  logic             coutMsb_q, coutMsb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             aBit, bBit, sliceBit, carryNext;
  logic             ovfNext, lessNext, cmpBit;
  logic [WIDTH-1:0] resultNext;

  // State and datapath registers; reset clears everything and aborts any run.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opA_q     <= '0;
      opB_q     <= '0;
      ctrl_q    <= '0;
      bonus_q   <= '0;
      shift_q   <= '0;
      k_q       <= '0;
      carry_q   <= 1'b0;
      eq_q      <= 1'b0;
      cinMsb_q  <= 1'b0;
      coutMsb_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      ctrl_q    <= ctrl_d;
      bonus_q   <= bonus_d;
      shift_q   <= shift_d;
      k_q       <= k_d;
      carry_q   <= carry_d;
      eq_q      <= eq_d;
      cinMsb_q  <= cinMsb_d;
      coutMsb_q <= coutMsb_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: accept in IDLE, one slice step per RUN cycle, fold flags in FINISH.
  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    ctrl_d     = ctrl_q;
    bonus_d    = bonus_q;
    shift_d    = shift_q;
    k_d        = k_q;
    carry_d    = carry_q;
    eq_d       = eq_q;
    cinMsb_d   = cinMsb_q;
    coutMsb_d  = coutMsb_q;
    result_d   = result_q;
    zero_d     = zero_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    aBit       = 1'b0;
    bBit       = 1'b0;
    sliceBit   = 1'b0;
    carryNext  = carry_q;
    ovfNext    = 1'b0;
    lessNext   = 1'b0;
    cmpBit     = 1'b0;
    resultNext = '0;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          opA_d   = bus.src1_i;
          opB_d   = bus.src2_i;
          ctrl_d  = bus.ALU_control_i;
          bonus_d = bus.bonus_control_i;
          shift_d = '0;
          k_d     = '0;
          // B_invert doubles as the +1 that completes two's-complement negation.
          carry_d = bus.ALU_control_i[2];
          eq_d    = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        aBit = opA_q[k_q] ^ ctrl_q[3];
        bBit = opB_q[k_q] ^ ctrl_q[2];
        case (ctrl_q[1:0])
          2'b00:   sliceBit = aBit & bBit;
          2'b01:   sliceBit = aBit | bBit;
          default: begin
            sliceBit  = aBit ^ bBit ^ carry_q;
            carryNext = (aBit & bBit) | (aBit & carry_q) | (bBit & carry_q);
          end
        endcase
        carry_d = carryNext;
        // Shifting in at the MSB leaves bit k in position k after WIDTH steps.
        shift_d = {sliceBit, shift_q[WIDTH-1:1]};
        eq_d    = eq_q & ~(opA_q[k_q] ^ opB_q[k_q]);
        if (k_q == LAST_K) begin
          cinMsb_d  = carry_q;
          coutMsb_d = carryNext;
          state_d   = FINISH;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      FINISH: begin
        ovfNext  = cinMsb_q ^ coutMsb_q;
        lessNext = shift_q[WIDTH-1] ^ ovfNext;
        case (bonus_q)
          3'b000:  cmpBit = lessNext;
          3'b001:  cmpBit = ~lessNext & ~eq_q;
          3'b010:  cmpBit = lessNext | eq_q;
          3'b011:  cmpBit = ~lessNext;
          3'b110:  cmpBit = eq_q;
          3'b100:  cmpBit = ~eq_q;
          default: cmpBit = 1'b0;
        endcase
        if (ctrl_q[1:0] == 2'b11) resultNext = {{(WIDTH-1){1'b0}}, cmpBit};
        else                      resultNext = shift_q;
        result_d = resultNext;
        zero_d   = (resultNext == '0);
        // Logic ops have no meaningful carry chain, so their flags read 0.
        cout_d   = ctrl_q[1] & coutMsb_q;
        ovf_d    = ctrl_q[1] & ovfNext;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_o     = (state_q != IDLE);
  assign bus.done_o     = done_q;
  assign bus.result_o   = result_q;
  assign bus.zero_o     = zero_q;
  assign bus.cout_o     = cout_q;
  assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_serial.sv
// Randomised and directed bench for alu_serial. Expected values come from an
// arithmetic reference model of the ALU operations and compare codes.
module tb_alu_serial;

  localparam int W = 32;
  localparam int LAT = W + 1;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
  } expect_t;

  logic clk_i = 1'b0;
  logic rst_n;

  always #5 clk_i = ~clk_i;

  alu_serial_if #(.WIDTH(W)) aluBus ();

  alu_serial #(.WIDTH(W)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (aluBus)
  );

  int nChecks = 0;
  int nFails  = 0;

  logic [W-1:0] obsRes;
  logic         obsZ, obsC, obsV;

  logic [3:0] legalCodes [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101};
  logic [W-1:0] specials [5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};

  // Reference: plain W-bit arithmetic and signed compares on the raw operands.
  function automatic expect_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [3:0] ctrl, input logic [2:0] bonus);
    expect_t e;
    logic [W-1:0] aa, bb;
    logic [W:0]   sum;
    logic         ovf, less, equal, cmp;
    aa    = ctrl[3] ? ~a : a;
    bb    = ctrl[2] ? ~b : b;
    sum   = {1'b0, aa} + {1'b0, bb} + (W+1)'(ctrl[2]);
    ovf   = (aa[W-1] == bb[W-1]) && (sum[W-1] != aa[W-1]);
    less  = $signed(a) < $signed(b);
    equal = (a == b);
    case (bonus)
      3'b000:  cmp = less;
      3'b001:  cmp = !less && !equal;
      3'b010:  cmp = less || equal;
      3'b011:  cmp = !less;
      3'b110:  cmp = equal;
      3'b100:  cmp = !equal;
      default: cmp = 1'b0;
    endcase
    e = '0;
    case (ctrl[1:0])
      2'b00: e.res = aa & bb;
      2'b01: e.res = aa | bb;
      2'b10: begin e.res = sum[W-1:0]; e.c = sum[W]; e.v = ovf; end
      default: begin e.res = W'(cmp); e.c = sum[W]; e.v = ovf; end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one operation, optionally poke start while busy, and check the outcome.
  task automatic applyStimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [3:0] ctrl, input logic [2:0] bonus, input int pulseAt);
    expect_t      e;
    logic [W-1:0] heldRes;
    int           lat, busyBad, earlyChange;
    bit           seen;
    e = refModel(a, b, ctrl, bonus);
    @(negedge clk_i);
    heldRes                = aluBus.result_o;
    aluBus.start_i         = 1'b1;
    aluBus.src1_i          = a;
    aluBus.src2_i          = b;
    aluBus.ALU_control_i   = ctrl;
    aluBus.bonus_control_i = bonus;
    @(posedge clk_i); #1;
    aluBus.start_i         = 1'b0;
    aluBus.src1_i          = $urandom;
    aluBus.src2_i          = $urandom;
    aluBus.ALU_control_i   = 4'($urandom);
    aluBus.bonus_control_i = 3'($urandom);
    checkOutput({tag, ".busyStart"}, 64'(aluBus.busy_o), 64'(1));
    lat = 0; busyBad = 0; earlyChange = 0; seen = 1'b0;
    for (int cyc = 1; cyc <= 100 && !seen; cyc++) begin
      if (cyc == pulseAt) aluBus.start_i = 1'b1;
      @(posedge clk_i); #1;
      aluBus.start_i = 1'b0;
      if (aluBus.done_o) begin
        seen = 1'b1;
        lat  = cyc;
      end else begin
        if (!aluBus.busy_o) busyBad++;
        if (aluBus.result_o !== heldRes) earlyChange++;
      end
    end
    checkOutput({tag, ".done"}, 64'(seen), 64'(1));
    checkOutput({tag, ".latency"}, 64'(lat), 64'(LAT));
    checkOutput({tag, ".busyGaps"}, 64'(busyBad), 64'(0));
    checkOutput({tag, ".heldResult"}, 64'(earlyChange), 64'(0));
    checkOutput({tag, ".busyEnd"}, 64'(aluBus.busy_o), 64'(0));
    checkOutput({tag, ".res"}, 64'(aluBus.result_o), 64'(e.res));
    checkOutput({tag, ".zero"}, 64'(aluBus.zero_o), 64'(e.z));
    checkOutput({tag, ".cout"}, 64'(aluBus.cout_o), 64'(e.c));
    checkOutput({tag, ".ovf"}, 64'(aluBus.overflow_o), 64'(e.v));
    obsRes = aluBus.result_o;
    obsZ   = aluBus.zero_o;
    obsC   = aluBus.cout_o;
    obsV   = aluBus.overflow_o;
    @(posedge clk_i); #1;
    checkOutput({tag, ".donePulse"}, 64'(aluBus.done_o), 64'(0));
  endtask

  initial begin
    expect_t      e1, e2;
    logic [W-1:0] ra, rb;
    logic [3:0]   rc;
    int           doneCount, cnt;
    bit           seen;

    rst_n                  = 1'b0;
    aluBus.start_i         = 1'b0;
    aluBus.src1_i          = '0;
    aluBus.src2_i          = '0;
    aluBus.ALU_control_i   = '0;
    aluBus.bonus_control_i = '0;

    // Power-up reset values
    #12;
    checkOutput("por.busy", 64'(aluBus.busy_o), 64'(0));
    checkOutput("por.done", 64'(aluBus.done_o), 64'(0));
    checkOutput("por.res",  64'(aluBus.result_o), 64'(0));
    checkOutput("por.zero", 64'(aluBus.zero_o), 64'(0));
    checkOutput("por.cout", 64'(aluBus.cout_o), 64'(0));
    checkOutput("por.ovf",  64'(aluBus.overflow_o), 64'(0));
    @(negedge clk_i);
    rst_n = 1'b1;

    // Directed arithmetic boundary cases
    applyStimulus("add_ovf", 32'h7FFF_FFFF, 32'h1, 4'b0010, 3'b000, 0);
    checkOutput("add_ovf.k.res", 64'(obsRes), 64'(32'h8000_0000));
    checkOutput("add_ovf.k.v", 64'(obsV), 64'(1));
    checkOutput("add_ovf.k.c", 64'(obsC), 64'(0));
    checkOutput("add_ovf.k.z", 64'(obsZ), 64'(0));
    applyStimulus("add_wrap", 32'hFFFF_FFFF, 32'h1, 4'b0010, 3'b000, 0);
    checkOutput("add_wrap.k.res", 64'(obsRes), 64'(0));
    checkOutput("add_wrap.k.c", 64'(obsC), 64'(1));
    checkOutput("add_wrap.k.z", 64'(obsZ), 64'(1));
    checkOutput("add_wrap.k.v", 64'(obsV), 64'(0));
    applyStimulus("sub_eq", 32'd5, 32'd5, 4'b0110, 3'b000, 0);
    checkOutput("sub_eq.k.z", 64'(obsZ), 64'(1));
    checkOutput("sub_eq.k.c", 64'(obsC), 64'(1));
    applyStimulus("nor0", 32'h0, 32'h0, 4'b1100, 3'b000, 0);
    checkOutput("nor0.k.res", 64'(obsRes), 64'(32'hFFFF_FFFF));
    applyStimulus("slt_neg", 32'h8000_0000, 32'h1, 4'b0111, 3'b000, 0);
    checkOutput("slt_neg.k.res", 64'(obsRes), 64'(1));
    applyStimulus("slt_pos", 32'h1, 32'h8000_0000, 4'b0111, 3'b000, 0);
    checkOutput("slt_pos.k.res", 64'(obsRes), 64'(0));

    // Bonus compares on equal operands
    applyStimulus("cmp_le", 32'd7, 32'd7, 4'b0111, 3'b010, 0);
    checkOutput("cmp_le.k.res", 64'(obsRes), 64'(1));
    applyStimulus("cmp_ge", 32'd7, 32'd7, 4'b0111, 3'b011, 0);
    checkOutput("cmp_ge.k.res", 64'(obsRes), 64'(1));
    applyStimulus("cmp_eq", 32'd7, 32'd7, 4'b0111, 3'b110, 0);
    checkOutput("cmp_eq.k.res", 64'(obsRes), 64'(1));
    applyStimulus("cmp_ne", 32'd7, 32'd7, 4'b0111, 3'b100, 0);
    checkOutput("cmp_ne.k.res", 64'(obsRes), 64'(0));
    applyStimulus("cmp_gt", 32'd7, 32'd7, 4'b0111, 3'b001, 0);
    checkOutput("cmp_gt.k.res", 64'(obsRes), 64'(0));
    applyStimulus("cmp_lt", 32'd7, 32'd7, 4'b0111, 3'b000, 0);
    checkOutput("cmp_lt.k.res", 64'(obsRes), 64'(0));

    // NAND leaves a nonzero result in place for the reset-abort test
    applyStimulus("nand", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1101, 3'b000, 0);
    checkOutput("nand.k.res", 64'(obsRes), 64'(32'h0FFF_0FFF));

    // Reset asserted at k=10 of an ADD aborts without a done pulse
    @(negedge clk_i);
    aluBus.start_i       = 1'b1;
    aluBus.src1_i        = 32'h1234_5678;
    aluBus.src2_i        = 32'h0101_0101;
    aluBus.ALU_control_i = 4'b0010;
    @(posedge clk_i); #1;
    aluBus.start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstmid.busy", 64'(aluBus.busy_o), 64'(0));
    checkOutput("rstmid.res",  64'(aluBus.result_o), 64'(0));
    checkOutput("rstmid.done", 64'(aluBus.done_o), 64'(0));
    checkOutput("rstmid.zero", 64'(aluBus.zero_o), 64'(0));
    doneCount = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (aluBus.done_o) doneCount++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk_i);
      if (aluBus.done_o) doneCount++;
    end
    checkOutput("rstmid.noDone", 64'(doneCount), 64'(0));
    applyStimulus("post_rst", 32'h1234_5678, 32'h0101_0101, 4'b0010, 3'b000, 0);

    // Start pulsed while busy must be ignored
    applyStimulus("busy_pulse", 32'h0000_00FF, 32'h0000_0F0F, 4'b0001, 3'b000, 5);

    // Back-to-back: start held high across done
    e1 = refModel(32'h0000_1000, 32'h0000_0234, 4'b0010, 3'b000);
    e2 = refModel(32'h0000_0050, 32'h0000_0060, 4'b0110, 3'b000);
    @(negedge clk_i);
    aluBus.start_i       = 1'b1;
    aluBus.src1_i        = 32'h0000_1000;
    aluBus.src2_i        = 32'h0000_0234;
    aluBus.ALU_control_i = 4'b0010;
    aluBus.bonus_control_i = 3'b000;
    @(posedge clk_i); #1;
    aluBus.src1_i        = 32'h0000_0050;
    aluBus.src2_i        = 32'h0000_0060;
    aluBus.ALU_control_i = 4'b0110;
    cnt = 0; seen = 1'b0;
    for (int cyc = 1; cyc <= 100 && !seen; cyc++) begin
      @(posedge clk_i); #1;
      if (aluBus.done_o) begin seen = 1'b1; cnt = cyc; end
    end
    checkOutput("b2b.first.latency", 64'(cnt), 64'(LAT));
    checkOutput("b2b.first.res", 64'(aluBus.result_o), 64'(e1.res));
    cnt = 0; seen = 1'b0;
    for (int cyc = 1; cyc <= 100 && !seen; cyc++) begin
      @(posedge clk_i); #1;
      if (cyc == 1) begin
        aluBus.start_i = 1'b0;
        checkOutput("b2b.second.busy", 64'(aluBus.busy_o), 64'(1));
      end
      if (cyc == 20) checkOutput("b2b.held", 64'(aluBus.result_o), 64'(e1.res));
      if (aluBus.done_o) begin seen = 1'b1; cnt = cyc; end
    end
    checkOutput("b2b.spacing", 64'(cnt), 64'(W + 2));
    checkOutput("b2b.second.res", 64'(aluBus.result_o), 64'(e2.res));
    checkOutput("b2b.second.zero", 64'(aluBus.zero_o), 64'(e2.z));
    checkOutput("b2b.second.cout", 64'(aluBus.cout_o), 64'(e2.c));

    // Randomised operations over all legal codes and compare selects
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : W'($urandom);
      if ($urandom_range(0, 5) == 0) rb = ra;
      rc = legalCodes[$urandom_range(0, 6)];
      applyStimulus($sformatf("rand%0d", i), ra, rb, rc, 3'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
